dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the RV32I core: the memory side of the core's
//  dmem interface (address, write data, op, write enable -> read data).
//  Holds a word-organised RAM, performs byte/half/word loads (sign/zero
//  extended) and byte-lane stores, registers read data (1-cycle latency),
//  and flags misaligned or out-of-range accesses. Single clock domain.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; RAM depth = 2**ADDR_WIDTH words
//  CNT_WIDTH   16  width of the load/store access counters
// PORTS
//  clock        in   1   single clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  dmemaddr     in   32  byte address
//  dmemdatain   in   32  store data; sub-word data taken from LSBs
//  dmemop       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU; others reserved
//  dmemwe       in   1   store request this cycle
//  dmemre       in   1   load request this cycle
//  dmemdataout  out  32  load result, valid the cycle after the request
//  dmemerr      out  1   sticky fault flag
//  dmemerraddr  out  32  byte address of the first fault
//  ld_cnt       out  CNT_WIDTH  completed loads, saturating
//  st_cnt       out  CNT_WIDTH  completed stores, saturating
// BEHAVIOUR
//  Reset: dmemdataout=0, dmemerr=0, dmemerraddr=0, ld_cnt=0, st_cnt=0.
//   RAM contents not cleared. Requests seen while reset=1 are ignored.
//  Word index = dmemaddr[ADDR_WIDTH+1:2]; lane = dmemaddr[1:0].
//  Fault if any of: dmemaddr[31:ADDR_WIDTH+2] != 0; H/HU with addr[0]=1;
//   W with addr[1:0]!=0; reserved op (011,110,111).
//   A faulting access is suppressed: no RAM write, dmemdataout <= 0, no
//   counter increment. If dmemerr=0, set dmemerr=1 and capture
//   dmemerraddr=dmemaddr. Later faults leave both unchanged until reset.
//  Store (dmemwe=1, no fault): B writes lane byte from datain[7:0];
//   H writes lanes {addr[1],0}+1..+0 from datain[15:0]; W writes all four
//   lanes. Other bytes of the word keep their value. BU/HU as store: fault.
//   st_cnt += 1 (hold at all-ones).
//  Load (dmemre=1, dmemwe=0, no fault): on the next edge dmemdataout <=
//   selected lane(s) of the RAM word as of the request cycle;
//   B/H sign-extend, BU/HU zero-extend, W whole word. ld_cnt += 1 (saturating).
//  dmemre=0 and dmemwe=0: dmemdataout holds its previous value.
//  dmemre=1 and dmemwe=1 together: the store is performed, the load is
//   ignored (dmemdataout holds, ld_cnt unchanged).
//  Load one cycle after a store to the same word returns post-store data.
//  Latency: load data at cycle N+1 for a request at cycle N; back-to-back
//   loads are supported every cycle (throughput 1/cycle).
//  Reset asserted mid-stream: the cycle with reset=1 discards its request;
//   a load issued the cycle before reset returns 0 (reset wins on dmemdataout).
// TESTING
//  1 SW 0x0000_0010 <- 0x8765_4321; LW 0x10 -> dmemdataout 0x8765_4321 next cycle.
//  2 After 1: LB 0x13 -> 0xFFFF_FF87; LBU 0x13 -> 0x0000_0087;
//    LH 0x12 -> 0xFFFF_8765; LHU 0x10 -> 0x0000_4321.
//  3 SB 0x11 <- 0xAA, then SH 0x12 <- 0x1234; LW 0x10 -> 0x1234_AA21;
//    st_cnt = 3 after tests 1-3.
//  4 LW 0x0000_0012 -> dmemerr=1, dmemerraddr=0x12, dmemdataout 0;
//    then SH 0x0000_1001 (further fault) -> dmemerraddr stays 0x12, RAM unchanged.
//  5 SW 0x0001_0000 (out of range, ADDR_WIDTH=10) -> no write, fault flagged;
//    LW 0x0 still returns its old value.
//  6 Back-to-back LW 0x0,0x4,0x8 with re=1 and we=1 in the middle cycle ->
//    middle store is performed, its load is skipped, ld_cnt=2; then reset ->
//    all outputs 0 and the RAM word stored earlier still reads back.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Groups the core <-> data-memory bus so both sides share one bundle.
//   master : core side, drives the request (address, store data, op, enables)
//            and observes the load result and the fault reporting.
//   slave  : memory side, receives the request and returns the load result,
//            the sticky fault flag and the captured fault address.
//   Signals:
//     dmemaddr     32  byte address
//     dmemdatain   32  store data (sub-word data in the LSBs)
//     dmemop        3  000 B, 001 H, 010 W, 100 BU, 101 HU
//     dmemwe        1  store request
//     dmemre        1  load request
//     dmemdataout  32  registered load result
//     dmemerr       1  sticky fault flag
//     dmemerraddr  32  byte address of the first fault
interface dmem_responder_if;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic        dmemre;
  logic [31:0] dmemdataout;
  logic        dmemerr;
  logic [31:0] dmemerraddr;

  modport master (
    output dmemaddr, dmemdatain, dmemop, dmemwe, dmemre,
    input  dmemdataout, dmemerr, dmemerraddr
  );

  modport slave (
    input  dmemaddr, dmemdatain, dmemop, dmemwe, dmemre,
    output dmemdataout, dmemerr, dmemerraddr
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory side of the RV32I core's data-memory port. Holds a word-organised
//   RAM of 2**ADDR_WIDTH words, performs byte/half/word loads with sign or
//   zero extension and byte-lane stores, returns load data one cycle after
//   the request, and reports misaligned / out-of-range / reserved-op accesses
//   through a sticky flag plus the address of the first fault.
//   Ports:
//     clock   in   rising-edge clock for all state
//     reset   in   synchronous active-high reset (RAM contents are kept)
//     bus     slave side of dmem_responder_if (request in, result/fault out)
//     ld_cnt  out  completed loads, saturating at all-ones
//     st_cnt  out  completed stores, saturating at all-ones
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_responder_if.slave      bus,
  output logic [CNT_WIDTH-1:0] ld_cnt,
  output logic [CNT_WIDTH-1:0] st_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]          dataout_q, dataout_d;
  logic                 err_q, err_d;
  logic [31:0]          erraddr_q, erraddr_d;
  logic [CNT_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_WIDTH-1:0] st_cnt_q, st_cnt_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;

  logic is_half, is_word, is_unsigned_sub, op_reserved;
  logic range_fault, align_fault, fault;
  logic do_store, do_load;

  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign word_idx = bus.dmemaddr[ADDR_WIDTH+1:2];
  assign lane     = bus.dmemaddr[1:0];
  // Asynchronous read so a load sees the word as it stands in the request
  // cycle, which already includes a store committed on the previous edge.
  assign rd_word  = mem_q[word_idx];

  // Access classification and fault detection. Unsigned sub-word ops are
  // meaningless for stores, so they are treated as faults there.
  always_comb begin
    is_half         = (bus.dmemop == OP_H)  || (bus.dmemop == OP_HU);
    is_word         = (bus.dmemop == OP_W);
    is_unsigned_sub = (bus.dmemop == OP_BU) || (bus.dmemop == OP_HU);
    op_reserved     = !((bus.dmemop == OP_B) || is_half || is_word || (bus.dmemop == OP_BU));
    range_fault     = (bus.dmemaddr[31:ADDR_WIDTH+2] != '0);
    align_fault     = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    fault           = (bus.dmemwe || bus.dmemre) &&
                      (range_fault || align_fault || op_reserved ||
                       (bus.dmemwe && is_unsigned_sub));
    do_store        = bus.dmemwe && !fault;
    // A simultaneous store takes priority; the load half is dropped.
    do_load         = bus.dmemre && !bus.dmemwe && !fault;
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = bus.dmemdatain;
    case (bus.dmemop)
      OP_B: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{bus.dmemdatain[7:0]}};
      end
      OP_H: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.dmemdatain[15:0]}};
      end
      OP_W: begin
        wr_be   = 4'b1111;
        wr_data = bus.dmemdatain;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = bus.dmemdatain;
      end
    endcase
    if (!do_store || reset) begin
      wr_be = 4'b0000;
    end
  end

  // Lane selection and sign/zero extension of the load result.
  always_comb begin
    case (lane)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.dmemop)
      OP_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      OP_BU:   ld_value = {24'h000000, ld_byte};
      OP_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      OP_HU:   ld_value = {16'h0000, ld_half};
      OP_W:    ld_value = rd_word;
      default: ld_value = 32'h0000_0000;
    endcase
  end

  // Next-state for result, fault capture and counters. Only the first fault
  // after reset is recorded; every faulting access zeroes the result.
  always_comb begin
    dataout_d = dataout_q;
    err_d     = err_q;
    erraddr_d = erraddr_q;
    ld_cnt_d  = ld_cnt_q;
    st_cnt_d  = st_cnt_q;
    if (fault) begin
      dataout_d = 32'h0000_0000;
      if (!err_q) begin
        err_d     = 1'b1;
        erraddr_d = bus.dmemaddr;
      end
    end else if (do_store) begin
      if (st_cnt_q != '1) begin
        st_cnt_d = st_cnt_q + 1'b1;
      end
    end else if (do_load) begin
      dataout_d = ld_value;
      if (ld_cnt_q != '1) begin
        ld_cnt_d = ld_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dataout_q <= 32'h0000_0000;
      err_q     <= 1'b0;
      erraddr_q <= 32'h0000_0000;
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
    end else begin
      dataout_q <= dataout_d;
      err_q     <= err_d;
      erraddr_q <= erraddr_d;
      ld_cnt_q  <= ld_cnt_d;
      st_cnt_q  <= st_cnt_d;
    end
  end

  // RAM is deliberately left out of reset; wr_be is already gated by reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) begin
        mem_q[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  assign bus.dmemdataout = dataout_q;
  assign bus.dmemerr     = err_q;
  assign bus.dmemerraddr = erraddr_q;
  assign ld_cnt          = ld_cnt_q;
  assign st_cnt          = st_cnt_q;

endmodule
